// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART TX byte port among NUM_REQ requesters.
// A grant is held for a whole packet and is dropped on a stall timeout.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   io_req_valid,
  input  logic [8*NUM_REQ-1:0] io_req_bits,
  input  logic [NUM_REQ-1:0]   io_req_last,
  output logic [NUM_REQ-1:0]   io_req_ready,
  output logic                 io_tx_valid,
  output logic [7:0]           io_tx_bits,
  input  logic                 io_tx_ready,
  output logic [NUM_REQ-1:0]   io_grant,
  output logic                 io_timeout,
  output logic [CNT_W-1:0]     io_bytes_sent,
  output logic [CNT_W-1:0]     io_timeouts
);

  localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned SUM_W   = IDX_W + 1;
  localparam int unsigned STALL_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [STALL_W-1:0]   stall_q, stall_d;
  logic                 timeout_q, timeout_d;
  logic [CNT_W-1:0]     bytes_q, bytes_d;
  logic [CNT_W-1:0]     touts_q, touts_d;

  logic                 win_found;
  logic [IDX_W-1:0]     win_idx;
  logic [SUM_W-1:0]     cand;
  logic [IDX_W-1:0]     cand_idx;
  logic                 owner_valid;
  logic                 handshake;
  logic [IDX_W-1:0]     next_ptr;

  // Round-robin search: first valid requester at or above the pointer, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    cand_idx  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = SUM_W'(ptr_q) + SUM_W'(k);
      if (cand >= SUM_W'(NUM_REQ)) begin
        cand = cand - SUM_W'(NUM_REQ);
      end
      cand_idx = IDX_W'(cand);
      if (!win_found && io_req_valid[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  // Next-state and datapath steering; the TX side is a pass-through of the owner.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    ptr_d        = ptr_q;
    grant_d      = grant_q;
    stall_d      = stall_q;
    timeout_d    = 1'b0;
    bytes_d      = bytes_q;
    touts_d      = touts_q;
    io_tx_valid  = 1'b0;
    io_tx_bits   = '0;
    io_req_ready = '0;
    owner_valid  = io_req_valid[owner_q];
    handshake    = 1'b0;
    next_ptr     = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);

    case (state_q)
      IDLE: begin
        stall_d = '0;
        if (win_found) begin
          state_d = LOCKED;
          owner_d = win_idx;
          grant_d = NUM_REQ'(1) << win_idx;
        end
      end
      LOCKED: begin
        io_tx_valid  = owner_valid;
        io_tx_bits   = io_req_bits[32'(owner_q) * 8 +: 8];
        io_req_ready = grant_q & {NUM_REQ{io_tx_ready}};
        handshake    = owner_valid & io_tx_ready;
        if (handshake && (bytes_q != '1)) begin
          bytes_d = bytes_q + CNT_W'(1);
        end
        if (owner_valid) begin
          // Valid-but-not-ready is backpressure, so the stall count restarts.
          stall_d = '0;
          if (handshake && io_req_last[owner_q]) begin
            state_d = IDLE;
            grant_d = '0;
            ptr_d   = next_ptr;
          end
        end else if (stall_q == STALL_W'(TIMEOUT - 1)) begin
          state_d   = IDLE;
          grant_d   = '0;
          ptr_d     = next_ptr;
          stall_d   = '0;
          timeout_d = 1'b1;
          if (touts_q != '1) begin
            touts_d = touts_q + CNT_W'(1);
          end
        end else begin
          stall_d = stall_q + STALL_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      ptr_q     <= '0;
      grant_q   <= '0;
      stall_q   <= '0;
      timeout_q <= 1'b0;
      bytes_q   <= '0;
      touts_q   <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      stall_q   <= stall_d;
      timeout_q <= timeout_d;
      bytes_q   <= bytes_d;
      touts_q   <= touts_d;
    end
  end

  assign io_grant      = grant_q;
  assign io_timeout    = timeout_q;
  assign io_bytes_sent = bytes_q;
  assign io_timeouts   = touts_q;

endmodule
